step_arb: RTL and testbench



---
 rtl/step_arb.sv | 181 ++++++++++++++++++
 tb/tb_step_arb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_arb.sv
// -----------------------------------------------------------------------------
// step_arb
//
// Shares one mod-5 step sequencer (phases A..E encoded 0..4) between NREQ
// requesters. One requester is granted at a time; while granted it receives
// one step pulse per cycle until its burst count is exhausted or it drops its
// request. A one-cycle done pulse marks the end of every grant, after which
// the sequencer is released. The phase register lives here, so the phase
// carries over from one grant to the next.
//
// Build option:
//   STEP_ARB_RR_EN  defined   -> round-robin arbitration, search starts one
//                                past the previous owner (requester 0 first
//                                after reset).
//                   undefined -> fixed priority, lowest requesting index wins;
//                                no round-robin pointer is built.
//
// Ports:
//   clk    in   1          rising-edge clock
//   rst    in   1          synchronous active-high reset
//   req    in   NREQ       request per requester, held until done
//   len    in   NREQ*LENW  burst length, requester i at [i*LENW +: LENW]
//   gnt    out  NREQ       registered one-hot grant
//   busy   out  1          a grant is active
//   step   out  1          step pulse, one phase advance per high cycle
//   phase  out  3          current phase 0..4
//   wrap   out  1          phase == 4
//   done   out  1          one-cycle end-of-grant pulse
// -----------------------------------------------------------------------------
module step_arb #(
    parameter int NREQ = 4,
    parameter int LENW = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] len,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic                 step,
    output logic [2:0]           phase,
    output logic                 wrap,
    output logic                 done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q,   gnt_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [LENW-1:0]   cnt_q,   cnt_d;
    logic [2:0]        phase_q, phase_d;
`ifdef STEP_ARB_RR_EN
    logic [IW-1:0]     rr_q,    rr_d;
`endif

    logic              found;
    logic [IW-1:0]     win;
    logic              step_en;

    // -------------------------------------------------------------------------
    // Arbitration: only consulted in IDLE.
    // -------------------------------------------------------------------------
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path leaves a value unassigned and no latch forms.
    always_comb begin
        found = 1'b0;
        win   = '0;
`ifdef STEP_ARB_RR_EN
        // Search begins one past the previous owner and wraps around.
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[(int'(rr_q) + i) % NREQ]) begin
                found = 1'b1;
                win   = IW'((int'(rr_q) + i) % NREQ);
            end
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
`endif
    end

    // A step needs both remaining count and a live request from the owner;
    // dropping the request suppresses the step in that very cycle.
    assign step_en = (state_q == RUN) && (cnt_q != '0) && req[owner_q];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
`ifdef STEP_ARB_RR_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    owner_d    = win;
                    // Length is captured here; later changes are ignored.
                    cnt_d      = len[int'(win)*LENW +: LENW];
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (step_en) begin
                    cnt_d   = cnt_q - LENW'(1);
                    phase_d = (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
                end else begin
                    // Count exhausted or owner aborted; leftover count is dropped.
                    state_d = DONE;
                end
            end
            DONE: begin
                gnt_d   = '0;
`ifdef STEP_ARB_RR_EN
                rr_d    = owner_q;
`endif
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            phase_q <= '0;
`ifdef STEP_ARB_RR_EN
            // Pointing at the last requester makes requester 0 first in line.
            rr_q    <= IW'(NREQ - 1);
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
`ifdef STEP_ARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign gnt   = gnt_q;
    assign busy  = |gnt_q;
    assign step  = step_en;
    assign phase = phase_q;
    assign wrap  = (phase_q == 3'd4);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_step_arb.sv
// -----------------------------------------------------------------------------
// tb_step_arb
//
// Bench for step_arb (NREQ=4, LENW=3). Each scenario pushes its expected
// per-cycle output records into a scoreboard queue, drives the stimulus one
// cycle at a time (inputs change 1 ns after the rising edge) and pops and
// compares one record at every falling edge. Expected records come from the
// burst timing: L step cycles, one idle RUN cycle, one DONE cycle, then IDLE.
// Works for both arbitration builds (STEP_ARB_RR_EN).
// -----------------------------------------------------------------------------
module tb_step_arb;

    localparam int NREQ = 4;
    localparam int LENW = 3;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*LENW-1:0] len;
    logic [NREQ-1:0]      gnt;
    logic                 busy;
    logic                 step;
    logic [2:0]           phase;
    logic                 wrap;
    logic                 done;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic            busy;
        logic            step;
        logic [2:0]      phase;
        logic            wrap;
        logic            done;
    } obs_t;

    obs_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_phase = 0;
`ifdef STEP_ARB_RR_EN
    int   exp_rr = NREQ - 1;
`endif

    step_arb #(.NREQ(NREQ), .LENW(LENW)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .busy  (busy),
        .step  (step),
        .phase (phase),
        .wrap  (wrap),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t mk(input logic [NREQ-1:0] g, input logic s, input int ph, input logic d);
        obs_t o;
        o.gnt   = g;
        o.busy  = |g;
        o.step  = s;
        o.phase = ph[2:0];
        o.wrap  = (ph == 4);
        o.done  = d;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.gnt   = gnt;
        o.busy  = busy;
        o.step  = step;
        o.phase = phase;
        o.wrap  = wrap;
        o.done  = done;
        return o;
    endfunction

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) sb.push_back(mk('0, 1'b0, exp_phase, 1'b0));
    endtask

    // Grant cycles of one burst in which 'nsteps' steps are actually taken.
    task automatic push_burst(input int who, input int nsteps);
        logic [NREQ-1:0] g;
        g = NREQ'(1 << who);
        for (int s = 0; s < nsteps; s++) begin
            sb.push_back(mk(g, 1'b1, exp_phase, 1'b0));
            exp_phase = (exp_phase + 1) % 5;
        end
        sb.push_back(mk(g, 1'b0, exp_phase, 1'b0));
        sb.push_back(mk(g, 1'b0, exp_phase, 1'b1));
`ifdef STEP_ARB_RR_EN
        exp_rr = who;
`endif
    endtask

    task automatic test_reset();
        int n;
        obs_t got, want;
        push_idle(3);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (c == 2) rst = 1'b0;
            @(negedge clk);
            got  = sample();
            want = sb.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset cycle %0d: got %p want %p", c, got, want);
            end
        end
    endtask

    // Four len=3 bursts on requester 0 with req held: phases 3,1,4,2.
    task automatic test_wrap();
        int n;
        obs_t got, want;
        push_idle(1);
        for (int b = 0; b < 4; b++) begin
            push_burst(0, 3);
            push_idle(1);
        end
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin req = 4'b0001; len = 12'd3; end
            if (c == 23) req = '0;
            @(negedge clk);
            got  = sample();
            want = sb.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL wrap cycle %0d: got %p want %p", c, got, want);
            end
        end
    endtask

    // len0=3; len0 rewritten to 7 mid-burst must not matter.
    task automatic test_single();
        int n;
        obs_t got, want;
        push_idle(1);
        push_burst(0, 3);
        push_idle(1);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin req = 4'b0001; len = 12'd3; end
            if (c == 2) len = 12'd7;
            if (c == 5) req = '0;
            @(negedge clk);
            got  = sample();
            want = sb.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL single cycle %0d: got %p want %p", c, got, want);
            end
        end
    endtask

    task automatic test_zero_len();
        int n;
        obs_t got, want;
        push_idle(1);
        push_burst(0, 0);
        push_idle(1);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin req = 4'b0001; len = '0; end
            if (c == 2) req = '0;
            @(negedge clk);
            got  = sample();
            want = sb.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL zero_len cycle %0d: got %p want %p", c, got, want);
            end
        end
    endtask

    // Requester 2, len=5, request dropped after two steps.
    task automatic test_abort();
        int n;
        obs_t got, want;
        push_idle(1);
        push_burst(2, 2);
        push_idle(1);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin req = 4'b0100; len = '0; len[8:6] = 3'd5; end
            if (c == 3) req = '0;
            @(negedge clk);
            got  = sample();
            want = sb.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL abort cycle %0d: got %p want %p", c, got, want);
            end
        end
    endtask

    // Reset during the second step; req held through reset is re-granted.
    task automatic test_reset_mid();
        int n;
        obs_t got, want;
        push_idle(1);
        for (int s = 0; s < 2; s++) begin
            sb.push_back(mk(4'b0001, 1'b1, exp_phase, 1'b0));
            exp_phase = (exp_phase + 1) % 5;
        end
        exp_phase = 0;
`ifdef STEP_ARB_RR_EN
        exp_rr = NREQ - 1;
`endif
        push_idle(2);
        push_burst(0, 4);
        push_idle(1);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin req = 4'b0001; len = 12'd4; end
            if (c == 2) rst = 1'b1;
            if (c == 4) rst = 1'b0;
            if (c == 10) req = '0;
            @(negedge clk);
            got  = sample();
            want = sb.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset_mid cycle %0d: got %p want %p", c, got, want);
            end
        end
    endtask

    // All four requesting, len=1 each, five grants back to back.
    task automatic test_contention();
        int n;
        int who;
        obs_t got, want;
        push_idle(1);
        for (int b = 0; b < 5; b++) begin
`ifdef STEP_ARB_RR_EN
            who = (exp_rr + 1) % NREQ;
`else
            who = 0;
`endif
            push_burst(who, 1);
            push_idle(1);
        end
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin req = 4'b1111; len = {4{3'd1}}; end
            if (c == 19) req = '0;
            @(negedge clk);
            got  = sample();
            want = sb.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL contention cycle %0d: got %p want %p", c, got, want);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        len = '0;
        test_reset();
        test_wrap();
        test_single();
        test_zero_len();
        test_abort();
        test_reset_mid();
        test_contention();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
